// File: rtl/des_pkg.sv
// Shared types and constants for the DES round-sequencing slice.
package des_pkg;

  localparam int DES_BLOCK_W  = 64;
  localparam int DES_ROUNDS   = 16;
  localparam int DES_SUBKEY_W = 48;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ROUND,
    DONE
  } des_ctrl_state_t;

endpackage

// File: rtl/des_round_counter.sv
// Round index counter: loads the first index for the chosen direction, steps
// once per enabled cycle and flags the final index of that direction.
module des_round_counter
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = DES_ROUNDS,
  parameter int RIDX_W     = $clog2(NUM_ROUNDS)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load,
  input  logic              dir,
  input  logic              en,
  output logic [RIDX_W-1:0] idx,
  output logic              last
);

  localparam logic [RIDX_W-1:0] TOP_IDX = RIDX_W'(NUM_ROUNDS - 1);
  localparam logic [RIDX_W-1:0] ONE     = RIDX_W'(1);

  // dir=1 counts down from the top index (decrypt key order)
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx <= '0;
    end else if (load) begin
      idx <= dir ? TOP_IDX : '0;
    end else if (en) begin
      idx <= dir ? (idx - ONE) : (idx + ONE);
    end
  end

  assign last = dir ? (idx == '0) : (idx == TOP_IDX);

endmodule

// File: rtl/des_round_controller.sv
// Sequences one DES block: accept, load strobe, NUM_ROUNDS round steps, swapped result.
// Optional feature: define DES_DECRYPT_EN to add the `decrypt` port (reverse round order).
module des_round_controller
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = DES_ROUNDS,
  parameter int DATA_W     = DES_BLOCK_W,
  parameter int RIDX_W     = $clog2(NUM_ROUNDS)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_block,
`ifdef DES_DECRYPT_EN
  input  logic              decrypt,
`endif
  input  logic              flush,
  output logic              des_start,
  output logic [DATA_W-1:0] des_in,
  input  logic [DATA_W-1:0] des_curr,
  output logic [RIDX_W-1:0] round_idx,
  output logic              key_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_block,
  output logic              busy
);

  localparam int HALF_W = DATA_W / 2;

  des_ctrl_state_t state;
  logic            dir;
  logic            ctr_load;
  logic            ctr_en;
  logic            ctr_last;

`ifdef DES_DECRYPT_EN
  logic dir_q;

  // Direction is captured with the block so it stays fixed for all its rounds
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dir_q <= 1'b0;
    end else if (state == IDLE && in_valid && !flush) begin
      dir_q <= decrypt;
    end
  end

  assign dir = dir_q;
`else
  assign dir = 1'b0;
`endif

  // flush freezes the counter so round_idx holds once the FSM leaves ROUND
  assign ctr_load = (state == LOAD) && !flush;
  assign ctr_en   = (state == ROUND) && !ctr_last && !flush;

  des_round_counter #(
    .NUM_ROUNDS(NUM_ROUNDS),
    .RIDX_W    (RIDX_W)
  ) u_round_counter (
    .clk  (clk),
    .n_rst(n_rst),
    .load (ctr_load),
    .dir  (dir),
    .en   (ctr_en),
    .idx  (round_idx),
    .last (ctr_last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      des_in    <= '0;
      des_start <= 1'b0;
      key_req   <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      des_start <= 1'b0;
      key_req   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            des_in    <= in_block;
            des_start <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          des_start <= 1'b0;
          key_req   <= 1'b1;
          state     <= ROUND;
        end
        ROUND: begin
          if (ctr_last) begin
            key_req   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The datapath is idle outside ROUND, so the swapped view stays stable in DONE
  assign out_block = {des_curr[HALF_W-1:0], des_curr[DATA_W-1:HALF_W]};
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_des_round_controller.sv
// Bench for des_round_controller with a Feistel datapath model and a stand-in subkey table.
module tb_des_round_controller;
  import des_pkg::*;

  localparam int DW = DES_BLOCK_W;
  localparam int NR = DES_ROUNDS;
  localparam logic [63:0] PLAIN = 64'hCC00CCFFF0AAF0AA;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_block = '0;
`ifdef DES_DECRYPT_EN
  logic          decrypt = 1'b0;
`endif
  logic          flush = 1'b0;
  logic          des_start;
  logic [DW-1:0] des_in;
  logic [DW-1:0] des_curr;
  logic [3:0]    round_idx;
  logic          key_req;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_block;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] enc_result;

  always #5 clk = ~clk;

  des_round_controller dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_block (in_block),
`ifdef DES_DECRYPT_EN
    .decrypt  (decrypt),
`endif
    .flush    (flush),
    .des_start(des_start),
    .des_in   (des_in),
    .des_curr (des_curr),
    .round_idx(round_idx),
    .key_req  (key_req),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_block(out_block),
    .busy     (busy)
  );

  // Subkey stand-in derived from key 133457799BBCDFF1; distinct per round
  function automatic logic [47:0] sk(input int i);
    logic [63:0] k;
    k = 64'h133457799BBCDFF1;
    return 48'((k ^ (k >> i)) ^ (64'(i) * 64'h9E3779B97F4A7C15));
  endfunction

  function automatic logic [31:0] f_round(input logic [31:0] r, input logic [47:0] k);
    logic [31:0] t;
    t = (r ^ k[31:0]) * 32'h9E3779B1;
    return {t[18:0], t[31:19]} ^ {k[47:32], k[47:32]} ^ r;
  endfunction

  // Whole-block reference: 16 Feistel rounds in key order, then the L/R swap
  function automatic logic [63:0] feistel_ref(input logic [63:0] blk, input bit dec);
    logic [31:0] l, r, t;
    l = blk[63:32];
    r = blk[31:0];
    for (int n = 0; n < NR; n++) begin
      t = r;
      r = l ^ f_round(r, sk(dec ? NR - 1 - n : n));
      l = t;
    end
    return {r, l};
  endfunction

  // Round datapath driven by the controller's strobes and round index
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) des_curr <= '0;
    else if (des_start) des_curr <= des_in;
    else if (key_req) des_curr <= {des_curr[31:0], des_curr[63:32] ^ f_round(des_curr[31:0], sk(int'(round_idx)))};
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy, des_start, key_req} !== 5'b10000) begin
      n_err++;
      $display("[TB] FAIL reset_flags: got %b want 10000", {in_ready, out_valid, busy, des_start, key_req});
    end
    n_cmp++;
    if (round_idx !== 4'd0 || des_in !== 64'd0) begin
      n_err++;
      $display("[TB] FAIL reset_regs: got idx=%0d des_in=%h want 0/0", round_idx, des_in);
    end
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, busy} !== 2'b10) begin
      n_err++;
      $display("[TB] FAIL reset_release_idle: got %b want 10", {in_ready, busy});
    end
  endtask

  task automatic test_single_block();
    logic [63:0] exp;
    exp = feistel_ref(PLAIN, 1'b0);
    enc_result = exp;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_block = PLAIN;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_cmp++;
    if ({des_start, in_ready, busy} !== 3'b101 || des_in !== PLAIN) begin
      n_err++;
      $display("[TB] FAIL single_load: got start/rdy/busy=%b des_in=%h want 101/%h", {des_start, in_ready, busy}, des_in, PLAIN);
    end
    for (int r = 0; r < NR; r++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({des_start, key_req, out_valid} !== 3'b010 || round_idx !== 4'(r)) begin
        n_err++;
        $display("[TB] FAIL single_round: got flags=%b idx=%0d want 010/%0d", {des_start, key_req, out_valid}, round_idx, r);
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || key_req !== 1'b0 || out_block !== exp) begin
      n_err++;
      $display("[TB] FAIL single_result: got ov=%b kr=%b blk=%h want 1/0/%h", out_valid, key_req, out_block, exp);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, in_ready, busy} !== 3'b010 || round_idx !== 4'd15) begin
      n_err++;
      $display("[TB] FAIL single_release: got ov/rdy/busy=%b idx=%0d want 010/15", {out_valid, in_ready, busy}, round_idx);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] blk, exp;
    int cyc;
    bit bad;
    blk = {$urandom, $urandom};
    exp = feistel_ref(blk, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_block = blk;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_cmp++;
    if (cyc != 17) begin
      n_err++;
      $display("[TB] FAIL bp_latency: got %0d cycles after load want 17", cyc);
    end
    in_valid = 1'b1;
    in_block = ~blk;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_block !== exp) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (bad || out_block !== exp) begin
      n_err++;
      $display("[TB] FAIL bp_hold: got blk=%h ov=%b rdy=%b want %h/1/0", out_block, out_valid, in_ready, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, in_ready, busy} !== 3'b010 || des_in !== blk) begin
      n_err++;
      $display("[TB] FAIL bp_release: got ov/rdy/busy=%b des_in=%h want 010/%h", {out_valid, in_ready, busy}, des_in, blk);
    end
  endtask

  task automatic test_flush();
    logic [63:0] blk, blk2;
    int cyc;
    bit seen;
    blk = {$urandom, $urandom};
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_block = blk;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!(key_req === 1'b1 && round_idx === 4'd7) && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_cmp++;
    if (cyc >= 40) begin
      n_err++;
      $display("[TB] FAIL flush_reach_r7: got timeout want round 7");
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    n_cmp++;
    if ({busy, in_ready, key_req, out_valid} !== 4'b0100 || round_idx !== 4'd7) begin
      n_err++;
      $display("[TB] FAIL flush_idle: got b/r/k/v=%b idx=%0d want 0100/7", {busy, in_ready, key_req, out_valid}, round_idx);
    end
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("[TB] FAIL flush_no_result: got out_valid=1 want 0");
    end
    in_valid = 1'b1;
    in_block = ~blk;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || des_in !== blk) begin
      n_err++;
      $display("[TB] FAIL flush_beats_valid: got busy=%b des_in=%h want 0/%h", busy, des_in, blk);
    end
    blk2 = {$urandom, $urandom};
    in_valid = 1'b1;
    in_block = blk2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_block !== feistel_ref(blk2, 1'b0)) begin
      n_err++;
      $display("[TB] FAIL flush_next_block: got ov=%b blk=%h want 1/%h", out_valid, out_block, feistel_ref(blk2, 1'b0));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    int cyc;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_block = {$urandom, $urandom};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!(key_req === 1'b1 && round_idx === 4'd3) && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    #2;
    n_rst = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, busy, out_valid, des_start, key_req} !== 5'b10000) begin
      n_err++;
      $display("[TB] FAIL arst_flags: got %b want 10000", {in_ready, busy, out_valid, des_start, key_req});
    end
    n_cmp++;
    if (round_idx !== 4'd0 || des_in !== 64'd0) begin
      n_err++;
      $display("[TB] FAIL arst_regs: got idx=%0d des_in=%h want 0/0", round_idx, des_in);
    end
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random_blocks();
    logic [63:0] blk, exp;
    bit dec;
    int cyc, r, w, idx;
    for (int i = 0; i < 8; i++) begin
      blk = {$urandom, $urandom};
      dec = 1'b0;
`ifdef DES_DECRYPT_EN
      dec = 1'($urandom_range(0, 1));
      decrypt = dec;
`endif
      exp = feistel_ref(blk, dec);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_block = blk;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cyc = 0;
      r = 0;
      while (out_valid !== 1'b1 && cyc < 40) begin
        if (key_req === 1'b1) begin
          idx = dec ? NR - 1 - r : r;
          n_cmp++;
          if (round_idx !== 4'(idx)) begin
            n_err++;
            $display("[TB] FAIL rand_round_idx: got %0d want %0d (dec=%0d)", round_idx, idx, dec);
          end
          r++;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      n_cmp++;
      if (cyc != 17 || r != NR) begin
        n_err++;
        $display("[TB] FAIL rand_latency: got %0d cycles/%0d rounds want 17/%0d", cyc, r, NR);
      end
      n_cmp++;
      if (out_block !== exp) begin
        n_err++;
        $display("[TB] FAIL rand_result: got %h want %h (dec=%0d)", out_block, exp, dec);
      end
      w = $urandom_range(0, 3);
      repeat (w) begin
        @(posedge clk);
        #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL rand_release: got rdy=%b ov=%b want 1/0", in_ready, out_valid);
      end
    end
`ifdef DES_DECRYPT_EN
    decrypt = 1'b0;
`endif
  endtask

`ifdef DES_DECRYPT_EN
  task automatic test_decrypt();
    int cyc, r;
    bit bad;
    decrypt = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_block = enc_result;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    decrypt = 1'b0;
    cyc = 0;
    r = 0;
    bad = 1'b0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      if (key_req === 1'b1) begin
        if (round_idx !== 4'(NR - 1 - r)) bad = 1'b1;
        r++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    n_cmp++;
    if (bad || r != NR) begin
      n_err++;
      $display("[TB] FAIL dec_order: got bad=%0d rounds=%0d want 0/%0d", bad, r, NR);
    end
    n_cmp++;
    if (out_block !== PLAIN) begin
      n_err++;
      $display("[TB] FAIL dec_result: got %h want %h", out_block, PLAIN);
    end
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_block();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random_blocks();
`ifdef DES_DECRYPT_EN
    test_decrypt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
